// File: rtl/rr_slave_arbiter.sv
// rr_slave_arbiter: two-master round-robin arbiter in front of a single slave port with per-transaction timeout
module rr_slave_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              slave_req,
  output logic              slave_cmd,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic              slave_ack,
  input  logic [DATA_W-1:0] slave_rdata,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_LOW, DONE} state_t;
  state_t            state_q, state_d;
  logic              ptr_q, ptr_d, win_q, win_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              sreq_q, sreq_d, scmd_q, scmd_d;
  logic [DATA_W-1:0] swd_q, swd_d, rd0_q, rd0_d, rd1_q, rd1_d, rdv;
  logic              ack0_q, ack1_q, busy_q, err_q, err_d, ld, tmo;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sreq_d  = sreq_q;
    scmd_d  = scmd_q;
    swd_d   = swd_q;
    err_d   = err_q;
    ld      = 1'b0;
    rdv     = slave_rdata;
    tmo     = 8'(cnt_q + 8'd1) == 8'(TIMEOUT);
    case (state_q)
      IDLE: if (!slave_ack && (m0_req || m1_req)) begin
        // m0 wins when alone or when m1 was served last
        win_d   = !(m0_req && (!m1_req || ptr_q));
        ptr_d   = win_d;
        scmd_d  = win_d ? m1_cmd : m0_cmd;
        swd_d   = win_d ? m1_wdata : m0_wdata;
        sreq_d  = 1'b1;
        cnt_d   = '0;
        state_d = GRANT;
      end
      GRANT, WAIT_LOW: begin
        cnt_d = cnt_q + 8'd1;
        if (tmo) begin
          sreq_d  = 1'b0;
          err_d   = 1'b1;
          ld      = !scmd_q;
          rdv     = '0;
          state_d = DONE;
        end else if (state_q == GRANT && slave_ack) begin
          sreq_d  = 1'b0;
          state_d = WAIT_LOW;
        end else if (state_q == WAIT_LOW && !slave_ack) begin
          ld      = !scmd_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd0_d = (ld && !win_q) ? rdv : rd0_q;
    rd1_d = (ld && win_q) ? rdv : rd1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      sreq_q  <= 1'b0;
      scmd_q  <= 1'b0;
      swd_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sreq_q  <= sreq_d;
      scmd_q  <= scmd_d;
      swd_q   <= swd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= state_d == DONE && !win_d;
      ack1_q  <= state_d == DONE && win_d;
      busy_q  <= state_d != IDLE;
      err_q   <= err_d;
    end
  end
  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rd0_q;
  assign m1_rdata    = rd1_q;
  assign slave_req   = sreq_q;
  assign slave_cmd   = scmd_q;
  assign slave_wdata = swd_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_rr_slave_arbiter.sv
// tb_rr_slave_arbiter: cycle-accurate directed vectors for the two-master arbiter, TIMEOUT = 8
module tb_rr_slave_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_req = 0, m0_cmd = 0, m1_req = 0, m1_cmd = 0, slave_ack = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, slave_rdata = 0;
  logic        m0_ack, m1_ack, slave_req, slave_cmd, busy, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, slave_wdata;
  int          n_vec = 0, n_bad = 0;
  rr_slave_arbiter #(.DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .slave_req(slave_req), .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
    .slave_ack(slave_ack), .slave_rdata(slave_rdata), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic m0r, m0c; logic [31:0] m0w;
    logic m1r, m1c; logic [31:0] m1w;
    logic sa; logic [31:0] sr;
    logic sq, sc; logic [31:0] sw;
    logic a0, a1; logic [31:0] r0, r1;
    logic bz, te;
  } vec_t;
  function automatic vec_t v(input logic m0r, m0c, input logic [31:0] m0w,
                             input logic m1r, m1c, input logic [31:0] m1w,
                             input logic sa, input logic [31:0] sr,
                             input logic sq, sc, input logic [31:0] sw,
                             input logic a0, a1, input logic [31:0] r0, r1,
                             input logic bz, te);
    vec_t x;
    x.m0r = m0r; x.m0c = m0c; x.m0w = m0w; x.m1r = m1r; x.m1c = m1c; x.m1w = m1w;
    x.sa = sa; x.sr = sr; x.sq = sq; x.sc = sc; x.sw = sw;
    x.a0 = a0; x.a1 = a1; x.r0 = r0; x.r1 = r1; x.bz = bz; x.te = te;
    return x;
  endfunction
  function automatic logic [101:0] pack_exp(input vec_t x);
    return {x.sq, x.sc, x.sw, x.a0, x.a1, x.r0, x.r1, x.bz, x.te};
  endfunction
  wire [101:0] act = {slave_req, slave_cmd, slave_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, timeout_err};
  task automatic check(input logic [101:0] exp, input string nm);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    m0_req = x.m0r; m0_cmd = x.m0c; m0_wdata = x.m0w;
    m1_req = x.m1r; m1_cmd = x.m1c; m1_wdata = x.m1w;
    slave_ack = x.sa; slave_rdata = x.sr;
    @(posedge clk);
    #1 check(pack_exp(x), nm);
  endtask
  vec_t tbl[$];
  string tnm[$];
  initial begin
    #2000000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r0, r1, d;
    // m0 read with a 2-cycle ack
    tbl.push_back(v(1,0,0, 0,0,0, 0,0,            1,0,0, 0,0, 0,0, 1,0)); tnm.push_back("t1_grant");
    tbl.push_back(v(1,0,0, 0,0,0, 1,0,            0,0,0, 0,0, 0,0, 1,0)); tnm.push_back("t1_ack_hi");
    tbl.push_back(v(1,0,0, 0,0,0, 1,0,            0,0,0, 0,0, 0,0, 1,0)); tnm.push_back("t1_ack_hi2");
    tbl.push_back(v(1,0,0, 0,0,0, 0,32'h12345678, 0,0,0, 1,0, 32'h12345678,0, 1,0)); tnm.push_back("t1_done");
    tbl.push_back(v(1,0,0, 0,0,0, 0,0,            0,0,0, 0,0, 32'h12345678,0, 0,0)); tnm.push_back("t1_idle");
    tbl.push_back(v(0,0,0, 0,0,0, 0,0,            0,0,0, 0,0, 32'h12345678,0, 0,0)); tnm.push_back("t1_quiet");
    // m1 write, ack after one wait cycle
    tbl.push_back(v(0,0,0, 1,1,32'hA5A5A5A5, 0,0, 1,1,32'hA5A5A5A5, 0,0, 32'h12345678,0, 1,0)); tnm.push_back("t2_grant");
    tbl.push_back(v(0,0,0, 1,1,32'hA5A5A5A5, 0,0, 1,1,32'hA5A5A5A5, 0,0, 32'h12345678,0, 1,0)); tnm.push_back("t2_hold");
    tbl.push_back(v(0,0,0, 1,1,32'hA5A5A5A5, 1,0, 0,1,32'hA5A5A5A5, 0,0, 32'h12345678,0, 1,0)); tnm.push_back("t2_ack_hi");
    tbl.push_back(v(0,0,0, 1,1,32'hA5A5A5A5, 0,32'hDEADBEEF, 0,1,32'hA5A5A5A5, 0,1, 32'h12345678,0, 1,0)); tnm.push_back("t2_done");
    tbl.push_back(v(0,0,0, 1,1,32'hA5A5A5A5, 0,0, 0,1,32'hA5A5A5A5, 0,0, 32'h12345678,0, 0,0)); tnm.push_back("t2_idle");
    // both masters read continuously: grants must alternate m0, m1, ...
    r0 = 32'h12345678; r1 = 0;
    for (int t = 0; t < 6; t++) begin
      d = 32'h10000000 + t;
      tbl.push_back(v(1,0,0, 1,0,0, 0,0, 1,0,0, 0,0, r0,r1, 1,0)); tnm.push_back($sformatf("t3_grant%0d", t));
      tbl.push_back(v(1,0,0, 1,0,0, 1,0, 0,0,0, 0,0, r0,r1, 1,0)); tnm.push_back($sformatf("t3_ack%0d", t));
      if (t % 2 == 0) r0 = d; else r1 = d;
      tbl.push_back(v(1,0,0, 1,0,0, 0,d, 0,0,0, t%2==0, t%2==1, r0,r1, 1,0)); tnm.push_back($sformatf("t3_done%0d", t));
      tbl.push_back(v(1,0,0, 1,0,0, 0,0, 0,0,0, 0,0, r0,r1, 0,0)); tnm.push_back($sformatf("t3_idle%0d", t));
    end
    // silent slave: abort 8 cycles after grant
    tbl.push_back(v(1,0,0, 0,0,0, 0,0, 1,0,0, 0,0, 32'h10000004,32'h10000005, 1,0)); tnm.push_back("t4_grant");
    for (int i = 1; i < 8; i++) begin
      tbl.push_back(v(1,0,0, 0,0,0, 0,0, 1,0,0, 0,0, 32'h10000004,32'h10000005, 1,0)); tnm.push_back($sformatf("t4_wait%0d", i));
    end
    tbl.push_back(v(1,0,0, 0,0,0, 0,0, 0,0,0, 1,0, 0,32'h10000005, 1,1)); tnm.push_back("t4_abort");
    tbl.push_back(v(1,0,0, 0,0,0, 0,0, 0,0,0, 0,0, 0,32'h10000005, 0,1)); tnm.push_back("t4_idle");
    tbl.push_back(v(0,0,0, 1,1,32'h0BADF00D, 1,0, 0,0,0, 0,0, 0,32'h10000005, 0,1)); tnm.push_back("t4_stale_ack");
    tbl.push_back(v(0,0,0, 1,1,32'h0BADF00D, 0,0, 1,1,32'h0BADF00D, 0,0, 0,32'h10000005, 1,1)); tnm.push_back("t4_regrant");
    tbl.push_back(v(0,0,0, 1,1,32'h0BADF00D, 1,0, 0,1,32'h0BADF00D, 0,0, 0,32'h10000005, 1,1)); tnm.push_back("t4_ack_hi");
    tbl.push_back(v(0,0,0, 1,1,32'h0BADF00D, 0,0, 0,1,32'h0BADF00D, 0,1, 0,32'h10000005, 1,1)); tnm.push_back("t4_done");
    tbl.push_back(v(0,0,0, 1,1,32'h0BADF00D, 0,0, 0,1,32'h0BADF00D, 0,0, 0,32'h10000005, 0,1)); tnm.push_back("t4_idle2");
    // ack held 5 cycles; data taken from the first ack-low cycle only
    tbl.push_back(v(1,0,0, 0,0,0, 0,0, 1,0,0, 0,0, 0,32'h10000005, 1,1)); tnm.push_back("t6_grant");
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(v(1,0,0, 0,0,0, 1,32'h55555555, 0,0,0, 0,0, 0,32'h10000005, 1,1)); tnm.push_back($sformatf("t6_ack_hi%0d", i));
    end
    tbl.push_back(v(1,0,0, 0,0,0, 0,32'hCAFEF00D, 0,0,0, 1,0, 32'hCAFEF00D,32'h10000005, 1,1)); tnm.push_back("t6_done");
    tbl.push_back(v(1,0,0, 0,0,0, 0,32'h99999999, 0,0,0, 0,0, 32'hCAFEF00D,32'h10000005, 0,1)); tnm.push_back("t6_idle");
    // reset state, then run the table
    #1 check('0, "reset_async");
    repeat (2) @(posedge clk);
    #1 check('0, "reset_held");
    @(negedge clk) rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], tnm[i]);
    // reset in WAIT_LOW with ack still high
    apply(v(1,0,0, 0,0,0, 0,0, 1,0,0, 0,0, 32'hCAFEF00D,32'h10000005, 1,1), "t5_grant");
    apply(v(1,0,0, 0,0,0, 1,0, 0,0,0, 0,0, 32'hCAFEF00D,32'h10000005, 1,1), "t5_wait_low");
    @(negedge clk);
    m0_req = 0; m1_req = 1; m1_cmd = 1; m1_wdata = 32'h00000077; rst = 1'b1;
    #1 check('0, "t5_reset_now");
    @(negedge clk) rst = 1'b0;
    apply(v(0,0,0, 1,1,32'h77, 1,0, 0,0,0, 0,0, 0,0, 0,0), "t5_stale_ack");
    apply(v(0,0,0, 1,1,32'h77, 1,0, 0,0,0, 0,0, 0,0, 0,0), "t5_stale_ack2");
    apply(v(0,0,0, 1,1,32'h77, 0,0, 1,1,32'h77, 0,0, 0,0, 1,0), "t5_grant_m1");
    apply(v(0,0,0, 1,1,32'h77, 1,0, 0,1,32'h77, 0,0, 0,0, 1,0), "t5_ack_hi");
    apply(v(0,0,0, 1,1,32'h77, 0,0, 0,1,32'h77, 0,1, 0,0, 1,0), "t5_done");
    apply(v(0,0,0, 0,0,0,     0,0, 0,1,32'h77, 0,0, 0,0, 0,0), "t5_idle");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
